// File: rtl/common_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package common;

    localparam int UART_DATA_BITS = 8;

    // 100 MHz / 115200 baud; both ends use this default so their bit timing matches.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO. The head entry appears on pop_data
// combinationally. A push is visible for pop only from the following cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra MSB, so equal indices with different MSBs mean full.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Advance the pointers; they wrap naturally at 2*DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is left unreset; entries are only read after they have been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. Bytes are queued in a small FIFO through a valid/ready
// handshake. A baud counter and frame FSM then shift them LSB first onto io_tx.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (0) on the line
// DATA  | data bit shift[0] on the line, eight times
// STOP  | stop bit (1); chains straight into START if another byte is queued
module uart_tx
    import common::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       io_tx,
    output logic       tx_busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);

    uart_tx_state_t      state;
    logic [BW-1:0]       baud_cnt;
    logic [IW-1:0]       bit_idx;
    logic [7:0]          shift;
    logic [7:0]          head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                bit_end;

    // tx_ready depends on FIFO state only; a pop in the same cycle does not free a slot.
    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign tx_busy   = (state != IDLE) || !fifo_empty;

    // Pop whenever the FSM is about to load a new frame.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state == IDLE)               fifo_pop = 1'b1;
            if (state == STOP && bit_end)    fifo_pop = 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Frame FSM; io_tx is loaded with the level of the upcoming bit so it stays a pure flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            io_tx    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    io_tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= head;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        io_tx    <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        io_tx    <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        bit_idx  <= bit_idx + IW'(1);
                        if (bit_idx == BIT_LAST) begin
                            io_tx <= 1'b1;
                            state <= STOP;
                        end else begin
                            io_tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            shift   <= head;
                            bit_idx <= '0;
                            io_tx   <= 1'b0;
                            state   <= START;
                        end else begin
                            io_tx <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    io_tx <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter. It is the transmit counterpart of the CPU's `io_rx` receive path and drives the new top-level pin `io_tx`.
- Frame format: 8N1, meaning 1 start bit (0), 8 data bits sent LSB first, and 1 stop bit (1).
- Bytes arrive through a valid/ready handshake and are buffered in a small FIFO, so the CPU or a debug/loader path can queue several bytes without stalling.
- A baud counter and a frame FSM serialize the bytes onto `io_tx`.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Must be >= 2.
- FIFO_DEPTH, 4: number of byte entries in the transmit FIFO. Must be a power of 2 and >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte this cycle.
- io_tx  output  1  serial line, idle high, registered output.
- tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Reset values (at the first edge with reset=1): io_tx=1, tx_ready=1, tx_busy=0, FSM=IDLE, FIFO empty, baud counter=0, bit index=0.
- Reset mid-frame: the frame is aborted, io_tx=1 after the edge, and all queued bytes are discarded.
- Handshake:
  - A byte is accepted at an edge where tx_valid && tx_ready.
  - tx_ready = !fifo_full. It is a combinational function of FIFO state only and never depends on tx_valid.
  - While tx_valid=1 and tx_ready=0, the source holds tx_data stable. Nothing is accepted.
  - When full, a same-cycle pop does not allow a push (tx_ready stays 0 that cycle).
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - io_tx=1.
  - If the FIFO is non-empty: pop the head into an 8-bit shift register, clear the baud counter, and go to START.
- START: io_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA:
  - io_tx=shift[0] for CLKS_PER_BIT cycles.
  - Then shift right and increment the bit index.
  - After bit index 7 completes, go to STOP.
- STOP:
  - io_tx=1 for CLKS_PER_BIT cycles.
  - Then, if the FIFO is non-empty: pop and go directly to START. Back-to-back frames have no idle gap.
  - Otherwise go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1.
  - A bit period ends when the count equals CLKS_PER_BIT-1.
  - The counter then wraps to 0.
- Latency:
  - A byte accepted at edge N into an empty FIFO while the FSM is IDLE is popped at edge N+1.
  - io_tx is 0 from edge N+1.
  - The full frame occupies exactly 10*CLKS_PER_BIT cycles.
- io_tx comes from a flop, with no combinational path from inputs.
- tx_busy = (FSM != IDLE) || !fifo_empty. It falls in the cycle after the last stop bit ends with an empty FIFO.
- FIFO:
  - Circular buffer with read/write pointers $clog2(FIFO_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - Pointers wrap naturally.
  - Simultaneous push and pop when not full and not empty: count unchanged and data order preserved.
  - Push into an empty FIFO while the FSM is in IDLE: the byte is not visible for pop until the next cycle (no fall-through).
- Capacity: FIFO_DEPTH queued bytes plus 1 in the shift register.

Decomposition:
- Shared package `common`:
  - `uart_tx_state_t` enum (IDLE, START, DATA, STOP).
  - Constant UART_DATA_BITS = 8.
  - Default CLKS_PER_BIT constant, shared with the receive side so both ends agree on baud.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - Ports: clk, reset, push, push_data, pop, pop_data, full, empty.
  - pop_data shows the head entry combinationally.
- uart_tx contains the handshake, baud counter, shift register and FSM.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Reset checks: hold reset 3 cycles → io_tx=1, tx_ready=1, tx_busy=0 throughout and after release.
- Single byte 0x55 accepted at edge N:
  - io_tx=0 on cycles N+1..N+4.
  - Then bits 1,0,1,0,1,0,1,0, each 4 cycles.
  - Then stop=1 for 4 cycles.
  - tx_busy falls at N+41.
- Back-to-back bytes 0xA5 then 0x3C pushed on consecutive cycles:
  - Two frames, 80 cycles total, stop bit of frame 1 directly followed by start of frame 2.
  - Decoded bytes are 0xA5, 0x3C.
- Overflow with tx_valid held high and incrementing data 0x01..0x06:
  - 5 bytes accepted (1 popped, 4 queued). tx_ready=0 while 0x06 waits.
  - 0x06 is accepted the cycle after the pop that starts 0x02's frame.
  - The line carries 0x01..0x06 in order.
- Reset mid-frame: assert reset during data bit 3 of 0x0F with 2 bytes queued → io_tx=1 next cycle, tx_busy=0, and no further frames after release.
- CLKS_PER_BIT=868, byte 0xC3: the receiver-model checker samples mid-bit and reads 0xC3. Frame length = 8680 cycles.
